// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states,
// owner IDs and the read-latency counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_EXT = 1'b1;

    localparam int CNT_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker (combinational).
// req[0]=CPU, req[1]=EXT; last_gnt in, gnt_valid/gnt_id out.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = OWN_CPU;
        if (&req) begin
            gnt_id = ~last_gnt;
        end else if (req[1]) begin
            gnt_id = OWN_EXT;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between CPU and EXT requesters.
// Ports: cpu_*/ext_* request/ack ports, ram_* RAM side, clr sync clear.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_t           state;
    logic             last_gnt;
    logic             owner;
    logic             lat_we;
    logic [CNT_W-1:0] cnt;

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arb2 u_rr (
        .req       ({ext_req, cpu_req}),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    assign sel_we    = (gnt_id == OWN_EXT) ? ext_we    : cpu_we;
    assign sel_addr  = (gnt_id == OWN_EXT) ? ext_addr  : cpu_addr;
    assign sel_wdata = (gnt_id == OWN_EXT) ? ext_wdata : cpu_wdata;

    assign cpu_stall = cpu_req & ~cpu_ack;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= OWN_EXT;
            owner     <= OWN_CPU;
            lat_we    <= 1'b0;
            cnt       <= '0;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            cpu_ack   <= 1'b0;
            ext_ack   <= 1'b0;
            cpu_rdata <= '0;
            ext_rdata <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            cpu_ack   <= 1'b0;
            ext_ack   <= 1'b0;
            if (clr) begin
                state     <= IDLE;
                cnt       <= '0;
                cpu_rdata <= '0;
                ext_rdata <= '0;
                last_gnt  <= OWN_EXT;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (gnt_valid) begin
                            owner     <= gnt_id;
                            last_gnt  <= gnt_id;
                            lat_we    <= sel_we;
                            ram_addr  <= sel_addr;
                            ram_wdata <= sel_wdata;
                            ram_write <= sel_we;
                            ram_read  <= ~sel_we;
                            state     <= ACCESS;
                        end
                    end
                    ACCESS: begin
                        if (lat_we) begin
                            cpu_ack <= (owner == OWN_CPU);
                            ext_ack <= (owner == OWN_EXT);
                            state   <= RESP;
                        end else begin
                            cnt   <= CNT_W'(RD_LAT - 1);
                            state <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            if (owner == OWN_CPU) begin
                                cpu_rdata <= ram_rdata;
                                cpu_ack   <= 1'b1;
                            end else begin
                                ext_rdata <= ram_rdata;
                                ext_ack   <= 1'b1;
                            end
                            state <= RESP;
                        end
                    end
                    RESP: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed table, corner sequences and random traffic vs a reference model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        clr;
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ext_req, ext_we, ext_ack;
    logic [8:0]  ext_addr;
    logic [31:0] ext_wdata, ext_rdata;
    logic        ram_read, ram_write;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    logic        b_cpu_req, b_ext_req;
    logic        b_cpu_ack, b_cpu_stall, b_ext_ack;
    logic [31:0] b_cpu_rdata, b_ext_rdata;
    logic        b_ram_read, b_ram_write;
    logic [8:0]  b_ram_addr;
    logic [31:0] b_ram_wdata, b_ram_rdata;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .ext_req(ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .ram_read(ram_read), .ram_write(ram_write),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RD_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .clr(clr),
        .cpu_req(b_cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .cpu_stall(b_cpu_stall),
        .ext_req(b_ext_req), .ext_we(ext_we),
        .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_ack(b_ext_ack), .ext_rdata(b_ext_rdata),
        .ram_read(b_ram_read), .ram_write(b_ram_write),
        .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata),
        .ram_rdata(b_ram_rdata)
    );

    // Behavioural RAMs: latency 1 and latency 3
    logic [31:0] mem_a [512];
    logic [31:0] mem_b [512];
    logic [31:0] rdq_a;
    logic [31:0] pb [3];

    assign ram_rdata   = rdq_a;
    assign b_ram_rdata = pb[2];

    always @(posedge clk) begin
        if (ram_write) mem_a[ram_addr] <= ram_wdata;
        if (ram_read) rdq_a <= mem_a[ram_addr];
    end

    always @(posedge clk) begin
        if (b_ram_write) mem_b[b_ram_addr] <= b_ram_wdata;
        pb[0] <= b_ram_read ? mem_b[b_ram_addr] : 32'hBAD0BAD0;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h",
                     name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input bit r, input bit we,
                         input logic [8:0] a, input logic [31:0] d);
        if (p) begin
            ext_req = r; ext_we = we;
            ext_addr = a; ext_wdata = d;
        end else begin
            cpu_req = r; cpu_we = we;
            cpu_addr = a; cpu_wdata = d;
        end
    endtask

    // Single transaction on one port from IDLE; cycle 0 = request cycle
    task automatic run_txn(input bit p, input bit we,
                           input logic [8:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd,
                           output int stall_n, output int str_cyc,
                           output int str_n, output int bad_n,
                           output int other_n);
        lat = -1; rd = '0; stall_n = 0; str_cyc = -1;
        str_n = 0; bad_n = 0; other_n = 0;
        drive(p, 1'b1, we, a, d);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cpu_stall) stall_n++;
            if (we ? ram_write : ram_read) begin
                str_n++;
                str_cyc = c;
            end
            if (we ? ram_read : ram_write) bad_n++;
            if (p ? cpu_ack : ext_ack) other_n++;
            if (p ? ext_ack : cpu_ack) begin
                lat = c;
                rd  = p ? ext_rdata : cpu_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    // Both ports request in the same cycle
    task automatic duel(input bit we,
                        input logic [8:0] ca, input logic [31:0] cw,
                        input logic [8:0] ea, input logic [31:0] ew,
                        output int cc, output int ec,
                        output logic [31:0] erd_at_c,
                        output logic [31:0] crd,
                        output logic [31:0] erd);
        cc = -1; ec = -1;
        erd_at_c = '0; crd = '0; erd = '0;
        drive(1'b0, 1'b1, we, ca, cw);
        drive(1'b1, 1'b1, we, ea, ew);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                cc = c; crd = cpu_rdata; erd_at_c = ext_rdata;
            end
            if (ext_ack) begin
                ec = c; erd = ext_rdata;
            end
            if (cc >= 0 && ec >= 0) break;
            @(posedge clk); #1;
            if (cc >= 0) cpu_req = 1'b0;
            if (ec >= 0) ext_req = 1'b0;
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        ext_req = 1'b0;
    endtask

    // Single CPU transaction on the RD_LAT=3 instance
    task automatic run_b(input bit we,
                         input logic [8:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd,
                         output int rd_n, output int rd_cyc);
        lat = -1; rd = '0; rd_n = 0; rd_cyc = -1;
        cpu_we = we; cpu_addr = a; cpu_wdata = d;
        b_cpu_req = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b_ram_read) begin
                rd_n++;
                rd_cyc = c;
            end
            if (b_cpu_ack) begin
                lat = c;
                rd  = b_cpu_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        b_cpu_req = 1'b0;
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lat, stall_n, str_cyc, str_n, bad_n, other_n;
        int cc, ec, k, seen;
        logic [31:0] rd, erd_at_c, crd, erd;
        bit          pend [2];
        bit          acked [2];
        bit          pwe [2];
        logic [8:0]  padr [2];
        logic [31:0] pwd [2];
        int          pstart [2];
        logic [31:0] model [16];
        int          last_p, last_c;

        for (int i = 0; i < 512; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        for (int i = 0; i < 16; i++) model[i] = '0;

        tbl[0] = '{1'b0, 1'b1, 9'h05A, 32'hDEADBEEF, 32'h0, 2};
        tbl[1] = '{1'b0, 1'b0, 9'h05A, 32'h0, 32'hDEADBEEF, 3};
        tbl[2] = '{1'b1, 1'b1, 9'h1FF, 32'h12345678, 32'h0, 2};
        tbl[3] = '{1'b1, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 3};
        tbl[4] = '{1'b0, 1'b0, 9'h1FF, 32'h0, 32'h12345678, 3};
        tbl[5] = '{1'b1, 1'b1, 9'h000, 32'hFFFFFFFF, 32'h0, 2};
        tbl[6] = '{1'b0, 1'b0, 9'h000, 32'h0, 32'hFFFFFFFF, 3};
        tbl[7] = '{1'b1, 1'b0, 9'h05A, 32'h0, 32'hDEADBEEF, 3};

        reset = 1'b0; clr = 1'b0;
        b_cpu_req = 1'b0; b_ext_req = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        repeat (2) @(posedge clk);
        #2;
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ext_ack", ext_ack, 0);
        check("rst_strobes", {ram_read, ram_write}, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ext_rdata", ext_rdata, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // Directed single-port vectors
        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wd,
                    lat, rd, stall_n, str_cyc, str_n, bad_n, other_n);
            check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
            if (!tbl[i].we)
                check($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            check($sformatf("vec%0d_stall", i), stall_n,
                  tbl[i].port ? 0 : tbl[i].lat);
            check($sformatf("vec%0d_strobe_cyc", i), str_cyc, 1);
            check($sformatf("vec%0d_strobe_n", i), str_n, 1);
            check($sformatf("vec%0d_bad_strobe", i), bad_n, 0);
            check($sformatf("vec%0d_other_ack", i), other_n, 0);
        end

        // Fresh reset, then read contention: CPU first
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        duel(1'b0, 9'h05A, 32'h0, 9'h1FF, 32'h0,
             cc, ec, erd_at_c, crd, erd);
        check("duel_cpu_cyc", cc, 3);
        check("duel_ext_cyc", ec, 7);
        check("duel_cpu_rdata", crd, 32'hDEADBEEF);
        check("duel_ext_hold", erd_at_c, 0);
        check("duel_ext_rdata", erd, 32'h12345678);

        // Continuous write contention: strict alternation
        drive(1'b0, 1'b1, 1'b1, 9'h020, 32'hAAAA0000);
        drive(1'b1, 1'b1, 1'b1, 9'h021, 32'h0000BBBB);
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk);
            if (cpu_ack || ext_ack) begin
                check($sformatf("alt%0d_owner", k), ext_ack, k % 2);
                check($sformatf("alt%0d_cyc", k), c, 2 + 3 * k);
                k++;
            end
            @(posedge clk); #1;
        end
        check("alt_count", k, 8);
        cpu_req = 1'b0;
        ext_req = 1'b0;
        @(posedge clk); #1;

        // Async reset in the middle of ACCESS
        drive(1'b0, 1'b1, 1'b0, 9'h05A, 32'h0);
        @(posedge clk); #2;
        check("arst_pre_read", ram_read, 1);
        #1 reset = 1'b0;
        #1;
        check("arst_strobes", {ram_read, ram_write}, 0);
        check("arst_acks", {cpu_ack, ext_ack}, 0);
        check("arst_cpu_rdata", cpu_rdata, 0);
        check("arst_ext_rdata", ext_rdata, 0);
        check("arst_ram_addr", ram_addr, 0);
        cpu_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        run_txn(1'b1, 1'b1, 9'h030, 32'h5555AAAA,
                lat, rd, stall_n, str_cyc, str_n, bad_n, other_n);
        check("arst_ext_lat", lat, 2);
        check("arst_ext_other", other_n, 0);

        // clr during WAIT of a CPU read
        run_txn(1'b0, 1'b0, 9'h05A, 32'h0,
                lat, rd, stall_n, str_cyc, str_n, bad_n, other_n);
        check("clr_pre_rdata", rd, 32'hDEADBEEF);
        drive(1'b0, 1'b1, 1'b0, 9'h000, 32'h0);
        seen = 0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == 2) clr = 1'b1;
            if (c == 3) begin
                clr = 1'b0;
                cpu_req = 1'b0;
            end
            @(negedge clk);
            if (cpu_ack) seen++;
            if (c == 3) check("clr_cpu_rdata", cpu_rdata, 0);
        end
        check("clr_no_ack", seen, 0);
        @(posedge clk); #1;
        duel(1'b1, 9'h040, 32'h11111111, 9'h041, 32'h22222222,
             cc, ec, erd_at_c, crd, erd);
        check("clr_duel_cpu_cyc", cc, 2);
        check("clr_duel_ext_cyc", ec, 5);

        // RD_LAT=3 instance at the top address
        run_b(1'b1, 9'h1FF, 32'hA5A55A5A, lat, rd, k, cc);
        check("lat3_wr_lat", lat, 2);
        run_b(1'b0, 9'h1FF, 32'h0, lat, rd, k, cc);
        check("lat3_rd_lat", lat, 5);
        check("lat3_rdata", rd, 32'hA5A55A5A);
        check("lat3_read_n", k, 1);
        check("lat3_read_cyc", cc, 1);

        // Random traffic against a transaction-level model
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; acked[p] = 0; pwe[p] = 0;
            padr[p] = '0; pwd[p] = '0; pstart[p] = 0;
        end
        last_p = -1; last_c = -100;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (acked[p]) begin
                    pend[p] = 0; acked[p] = 0;
                    drive(p[0], 1'b0, 1'b0, '0, '0);
                end
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]   = 1;
                    pstart[p] = cyc;
                    pwe[p]    = 1'($urandom_range(0, 1));
                    padr[p]   = 9'h100 + 9'($urandom_range(0, 15));
                    pwd[p]    = $urandom;
                    drive(p[0], 1'b1, pwe[p], padr[p], pwd[p]);
                end
            end
            @(negedge clk);
            check("rnd_strobes", ram_read & ram_write, 0);
            check("rnd_one_ack", cpu_ack & ext_ack, 0);
            for (int p = 0; p < 2; p++) begin
                int q;
                bit a, unfair;
                logic [31:0] r;
                q = 1 - p;
                a = p ? ext_ack : cpu_ack;
                r = p ? ext_rdata : cpu_rdata;
                if (a) begin
                    check($sformatf("rnd_ack_pend%0d", p), pend[p], 1);
                    if (pend[p]) begin
                        if (pwe[p])
                            model[padr[p][3:0]] = pwd[p];
                        else
                            check($sformatf("rnd_rdata%0d", p),
                                  r, model[padr[p][3:0]]);
                    end
                    unfair = (last_p == p) && pend[q] &&
                             (pstart[q] <= last_c + 1 ||
                              pstart[q] <= pstart[p]);
                    check($sformatf("rnd_fair%0d", p), unfair, 0);
                    last_p = p;
                    last_c = cyc;
                    acked[p] = 1;
                end else if (pend[p]) begin
                    check($sformatf("rnd_wait%0d", p),
                          (cyc - pstart[p]) > 10, 0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port RAM (clk, read, write, address_in, data_input, data_output) between two requesters:
  - CPU port: MAR/MDR path driven by the control unit.
  - EXT port: program loader / debug access.
- Sequences every RAM access as a fixed state walk, round-robins contending requests, and returns a one-cycle ack with registered read data.
- Sits between the datapath and memory_ram; asserts cpu_stall so the control unit holds its memory T-state.

Parameters:
- ADDR_W, 9, RAM word-address width (512 words).
- DATA_W, 32, data width.
- RD_LAT, 1, RAM read latency in clocks: data_output is valid RD_LAT cycles after the cycle read is sampled. Legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- clr  in  1  synchronous clear from the control unit, active-high.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  word address (MAR low bits).
- cpu_wdata  in  DATA_W  write data (MDR).
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack is high and held until the next CPU read ack.
- cpu_stall  out  1  equals cpu_req AND NOT cpu_ack.
- ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rdata: same widths and rules as the CPU port. No stall output on this port.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM data_output.

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its we/addr/wdata and owner ID, go to ACCESS.
- Arbitration:
  - Single requester wins.
  - Both requesting: the port not granted last wins.
  - last_gnt resets to EXT, so the CPU wins the first contention.
  - last_gnt updates on every grant.
- ACCESS (exactly one cycle):
  - ram_addr and ram_wdata driven from the latched values.
  - ram_write = latched we; ram_read = NOT latched we.
  - Write: go to RESP.
  - Read: load the 3-bit counter with RD_LAT-1 and go to WAIT.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: capture ram_rdata into the owner's rdata register and go to RESP.
- RESP: owner's ack = 1 for exactly one cycle, then go to IDLE.
- Latency, with the request seen in IDLE at cycle 0: write ack at cycle 2; read ack at cycle 2+RD_LAT (cycle 3 at default).
- Throughput: at most one access per 3 (write) or 3+RD_LAT (read) cycles. The earliest re-grant is the IDLE cycle after RESP.
- Strobes: ram_read and ram_write are 0 outside ACCESS and are never both 1. ram_addr and ram_wdata hold their latched values outside ACCESS.
- The non-owner port sees no ack and no rdata change.
- Outputs during reset:
  - All acks, strobes, rdata registers, ram_addr and ram_wdata are 0.
  - State = IDLE; last_gnt = EXT.
- Reset mid-operation: the in-flight transaction is dropped with no ack. A write already sampled by RAM in ACCESS is not undone.
- clr:
  - At the next edge, forces IDLE, clears the counter and both rdata registers, and sets last_gnt = EXT.
  - If clr is high during ACCESS, that cycle's strobe is still issued (RAM samples it on the same edge), but no ack follows.
  - clr has priority over all transitions.
- Request withdrawn before ack: a protocol violation. The arbiter completes the access and pulses ack anyway.
- Request arriving while busy: waits in queue and is arbitrated at the next IDLE.
- Both requests asserted continuously: grants strictly alternate CPU, EXT, CPU, ...

Decomposition:
- Package mem_arb_pkg holds:
  - State encoding localparams (IDLE=2'd0, ACCESS=2'd1, WAIT=2'd2, RESP=2'd3).
  - Owner IDs (OWN_CPU=1'b0, OWN_EXT=1'b1).
  - Counter width constant (3).
- Sub-module rr_arb2: combinational two-requester round-robin picker.
  - Inputs: req[1:0], last_gnt.
  - Outputs: gnt_valid, gnt_id.
  - Instantiated once.

Test Plan:
- CPU write then read: cpu_req, we=1, addr=0x05A, wdata=0xDEADBEEF → ram_write high on cycle 1, cpu_ack on cycle 2. Then read of 0x05A → cpu_ack on cycle 3 with cpu_rdata=0xDEADBEEF; cpu_stall high exactly cycles 0-2.
- Contention: CPU and EXT both request reads in the same cycle after reset → CPU acked first. EXT gets ACCESS in the first cycle after returning to IDLE and is acked 3 cycles later. ext_rdata is unchanged during the CPU ack.
- Continuous contention: both requesting with writes for 8 grants → grant order CPU, EXT, CPU, EXT, ...; one ack every 3 cycles.
- RD_LAT=3 build: read addr 0x1FF (ADDR_W boundary) → ack at cycle 5 with correct data; ram_read high only in cycle 1.
- clr in WAIT: clr pulsed during a CPU read's WAIT → IDLE next edge, no cpu_ack, cpu_rdata=0, next contention won by CPU.
- Async reset: reset low mid-ACCESS between clock edges → strobes, acks and rdata go to 0 immediately. After release, a single EXT request completes normally.
